// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver
//   Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB first,
//   parity, stop) and holds the received scan code for a consumer.
//
//   Parameters:
//     FILTER_LEN     - consecutive equal synchronized ps2_clk samples needed
//                      before the filtered clock level changes
//     TIMEOUT_CYCLES - max clk cycles between falling edges inside a frame
//   Ports:
//     clk        in   system clock, rising edge
//     clr        in   synchronous active-high reset
//     ps2_clk    in   asynchronous PS/2 clock line
//     ps2_data   in   asynchronous PS/2 data line
//     code_ack   in   consumer accepts the held code
//     code       out  last accepted scan code
//     code_valid out  code holds an unacknowledged byte
//     overrun    out  sticky: good frame arrived while a code was pending
//     frame_err  out  one-cycle pulse per discarded frame
//   Build option:
//     PS2_PARITY_CHECK_EN - when defined, frames must carry odd parity over
//                           data+parity bits; otherwise parity is ignored.
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       code_ack,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       overrun,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Two-flop synchronizers; bit 0 = ps2_clk, bit 1 = ps2_data.
    // Both idle high so reset values match the bus idle level.
    logic [1:0] line_in;
    logic [1:0] line_sync;
    assign line_in = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (clr) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= line_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign line_sync[gi] = sync_reg;
        end
    endgenerate

    logic clk_s;
    logic data_s;
    assign clk_s  = line_sync[0];
    assign data_s = line_sync[1];

    // Glitch filter: counts consecutive samples that disagree with the
    // filtered level; the level flips on the FILTER_LEN-th such sample.
    logic           filt_reg;
    logic [FCW-1:0] fcnt_reg;
    logic           filt_flip;
    logic           fall;

    assign filt_flip = (clk_s != filt_reg) && (fcnt_reg == FCW'(FILTER_LEN - 1));
    // Strobe is asserted in the cycle the level is about to go 1->0, so the
    // FSM samples data_s at the same edge that updates the filtered level.
    assign fall      = filt_flip && filt_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            filt_reg <= 1'b1;
            fcnt_reg <= '0;
        end else if (clk_s == filt_reg) begin
            fcnt_reg <= '0;
        end else if (filt_flip) begin
            filt_reg <= ~filt_reg;
            fcnt_reg <= '0;
        end else begin
            fcnt_reg <= fcnt_reg + 1'b1;
        end
    end

    // Frame FSM
    state_t         state_reg, state_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [7:0]     shift_reg, shift_next;
    logic [TCW-1:0] tout_reg, tout_next;
    logic           tout_hit;
    logic           frame_good;
    logic           deliver;
    logic           discard;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_reg;
    always_ff @(posedge clk) begin
        if (clr) begin
            parity_reg <= 1'b0;
        end else if (state_reg == PARITY && fall) begin
            parity_reg <= data_s;
        end
    end
    assign frame_good = ^{shift_reg, parity_reg};
`else
    assign frame_good = 1'b1;
`endif

    assign tout_hit = (state_reg != IDLE) && !fall &&
                      (tout_reg == TCW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        tout_next    = (state_reg == IDLE || fall) ? '0 : tout_reg + 1'b1;
        deliver      = 1'b0;
        discard      = 1'b0;
        case (state_reg)
            IDLE: begin
                // A high "start" bit is line noise; ignore it silently.
                if (fall && !data_s) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next = {data_s, shift_reg[7:1]};
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (data_s && frame_good) begin
                        deliver = 1'b1;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (tout_hit) begin
            state_next = IDLE;
            tout_next  = '0;
            discard    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
            tout_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tout_reg    <= tout_next;
        end
    end

    // Output holding register with acknowledge / overrun handling
    logic [7:0] code_reg;
    logic       valid_reg;
    logic       overrun_reg;
    logic       frame_err_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            code_reg      <= 8'h00;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= discard;
            if (deliver) begin
                if (valid_reg && !code_ack) begin
                    // Pending code is kept; newcomer is dropped and flagged.
                    overrun_reg <= 1'b1;
                end else begin
                    code_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end
            end else if (code_ack && valid_reg) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign code       = code_reg;
    assign code_valid = valid_reg;
    assign overrun    = overrun_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal synchronized ps2_clk samples required to change the filtered clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 10000, meaning maximum clk cycles allowed between two filtered ps2_clk falling edges inside a frame.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  asynchronous PS/2 clock line from keyboard.
REQ-006 SHALL have port ps2_data  input  1  asynchronous PS/2 data line from keyboard.
REQ-007 SHALL have port code_ack  input  1  consumer accepts the held scan code.
REQ-008 SHALL have port code  output  8  last accepted scan code, held until replaced.
REQ-009 SHALL have port code_valid  output  1  level; code holds an unacknowledged byte.
REQ-010 SHALL have port overrun  output  1  sticky; a good frame arrived while code_valid was high and code_ack low.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on any discarded frame.

Function
REQ-012 SHALL pass ps2_clk and ps2_data each through a two-flop synchronizer before any use.
REQ-013 SHALL change the filtered clock level only after FILTER_LEN consecutive identical synchronized samples; filtered level resets to 1.
REQ-014 SHALL generate a one-cycle falling-edge strobe when the filtered level goes 1->0; all data sampling uses synchronized ps2_data on that strobe.
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: strobe with data=0 -> DATA, bit count=0; strobe with data=1 -> stay IDLE, no error.
REQ-017 DATA: each strobe shifts data in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: strobe captures parity bit -> STOP.
REQ-019 STOP: strobe with data=1 and frame good -> IDLE plus delivery; data=0 -> IDLE plus frame_err.
REQ-020 Delivery SHALL load code and set code_valid on the clk cycle after the stop-bit strobe (latency 1).
REQ-021 code_ack while code_valid=1 SHALL clear code_valid next cycle; code_ack while code_valid=0 SHALL be ignored.
REQ-022 Delivery while code_valid=1 and code_ack=0 SHALL leave code unchanged, keep code_valid=1, set overrun.
REQ-023 Delivery in the same cycle as code_ack with code_valid=1 SHALL load the new code, keep code_valid=1, not set overrun.
REQ-024 Outside IDLE, a timeout counter SHALL clear on each strobe; reaching TIMEOUT_CYCLES SHALL force IDLE and pulse frame_err.
REQ-025 A discarded frame SHALL not alter code, code_valid or overrun.
REQ-026 frame_err SHALL be high for exactly one cycle per discarded frame.

Reset
REQ-027 clr=1 at a clk edge SHALL set state=IDLE, code=8'h00, code_valid=0, overrun=0, frame_err=0, bit count=0, timeout counter=0, shift register=0, synchronizers and filtered level=1.
REQ-028 clr SHALL take priority over every other event, including mid-frame and simultaneous delivery.
REQ-029 A frame partially received before clr SHALL never be delivered.

Configuration
REQ-030 Macro PS2_PARITY_CHECK_EN defined: frame is good only if the 8 data bits plus parity bit have odd parity; otherwise STOP exits with frame_err and no delivery.
REQ-031 Macro PS2_PARITY_CHECK_EN undefined: parity bit is sampled and ignored; only the stop bit decides frame goodness.

Verification
REQ-032 Frame 0x1C, parity 0, stop 1, code_ack low -> code=8'h1C, code_valid=1 one cycle after stop strobe, frame_err never high.
REQ-033 Frame 0x1C with parity 1 -> with PS2_PARITY_CHECK_EN: one frame_err pulse, code_valid stays 0; without: code=8'h1C, code_valid=1.
REQ-034 Frames 0x1C then 0x32 without code_ack -> code=8'h1C, code_valid=1, overrun=1; pulse code_ack -> code_valid=0, overrun stays 1.
REQ-035 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10 cycles -> one frame_err pulse, state IDLE; following frame 0x32 delivered correctly.
REQ-036 Frame 0x1C with stop bit 0 -> one frame_err pulse, no delivery; clr asserted after 5 data bits of a later frame -> all outputs at reset values, no delivery.
